// File: rtl/hls_mul_pipe_sat.sv
`default_nettype none
// hls_mul_pipe_sat -- pipelined multi-lane signed multiplier with fixed-point post-shift,
// optional round-half-up and runtime wrap/saturate narrowing. Rev 1.0
module hls_mul_pipe_sat #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 16,
  parameter int DOUT_WIDTH = 16,
  parameter int LANES      = 1,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 0
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          ce,
  input  logic                          in_valid,
  input  logic [LANES*DIN0_WIDTH-1:0]   din0,
  input  logic [LANES*DIN1_WIDTH-1:0]   din1,
  input  logic                          sat_en,
  input  logic                          rnd_en,
  output logic                          out_valid,
  output logic [LANES*DOUT_WIDTH-1:0]   dout,
  output logic [LANES-1:0]              ovf
);

  localparam int W    = DIN0_WIDTH + DIN1_WIDTH;
  localparam int C_HS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [W:0] C_HALF = (SHIFT > 0) ? ((W+1)'(1) << C_HS) : {(W+1){1'b0}};
  localparam logic [DOUT_WIDTH-1:0] C_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] C_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  logic [LANES*DIN0_WIDTH-1:0] w_mul_a;
  logic [LANES*DIN1_WIDTH-1:0] w_mul_b;
  logic [LANES*W-1:0]          w_mul_p;
  logic [LANES*W-1:0]          w_fin_p;
  logic                        w_fin_vld;
  logic                        w_fin_sat;
  logic                        w_fin_rnd;
  logic [LANES*DOUT_WIDTH-1:0] w_nar_d;
  logic [LANES-1:0]            w_nar_o;

  logic                        r_out_vld;
  logic [LANES*DOUT_WIDTH-1:0] r_dout;
  logic [LANES-1:0]            r_ovf;

  for (genvar i = 0; i < LANES; i++) begin : g_mul
    logic signed [DIN0_WIDTH-1:0] w_a;
    logic signed [DIN1_WIDTH-1:0] w_b;
    assign w_a = w_mul_a[i*DIN0_WIDTH +: DIN0_WIDTH];
    assign w_b = w_mul_b[i*DIN1_WIDTH +: DIN1_WIDTH];
    // Full-width product: MIN*MIN = 2^(W-2) still fits, so no internal overflow.
    assign w_mul_p[i*W +: W] = W'(w_a) * W'(w_b);
  end

  if (NUM_STAGE == 1) begin : g_comb
    assign w_mul_a   = din0;
    assign w_mul_b   = din1;
    assign w_fin_p   = w_mul_p;
    assign w_fin_vld = in_valid;
    assign w_fin_sat = sat_en;
    assign w_fin_rnd = rnd_en;
  end else begin : g_pipe
    logic [LANES*DIN0_WIDTH-1:0] r_a;
    logic [LANES*DIN1_WIDTH-1:0] r_b;
    logic [NUM_STAGE-2:0]        r_vld;
    logic [NUM_STAGE-2:0]        r_sat;
    logic [NUM_STAGE-2:0]        r_rnd;

    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
        r_a   <= '0;
        r_b   <= '0;
        r_vld <= '0;
        r_sat <= '0;
        r_rnd <= '0;
      end else if (ce) begin
        r_a      <= din0;
        r_b      <= din1;
        r_vld[0] <= in_valid;
        r_sat[0] <= sat_en;
        r_rnd[0] <= rnd_en;
        for (int s = 1; s < NUM_STAGE-1; s++) begin
          r_vld[s] <= r_vld[s-1];
          r_sat[s] <= r_sat[s-1];
          r_rnd[s] <= r_rnd[s-1];
        end
      end
    end

    assign w_mul_a   = r_a;
    assign w_mul_b   = r_b;
    assign w_fin_vld = r_vld[NUM_STAGE-2];
    assign w_fin_sat = r_sat[NUM_STAGE-2];
    assign w_fin_rnd = r_rnd[NUM_STAGE-2];

    if (NUM_STAGE == 2) begin : g_pdir
      assign w_fin_p = w_mul_p;
    end else begin : g_preg
      // Product delay line; synthesis may retime the multiplier across it.
      logic [LANES*W-1:0] r_p [NUM_STAGE-2];
      always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
          for (int k = 0; k < NUM_STAGE-2; k++) r_p[k] <= '0;
        end else if (ce) begin
          r_p[0] <= w_mul_p;
          for (int k = 1; k < NUM_STAGE-2; k++) r_p[k] <= r_p[k-1];
        end
      end
      assign w_fin_p = r_p[NUM_STAGE-3];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_nar
    logic signed [W:0]         w_r;
    logic signed [W:0]         w_s;
    logic [W-DOUT_WIDTH+1:0]   w_hi;
    logic                      w_ov;
    // One guard bit so the rounding increment can never wrap.
    assign w_r  = {w_fin_p[i*W+W-1], w_fin_p[i*W +: W]} + (w_fin_rnd ? C_HALF : {(W+1){1'b0}});
    assign w_s  = w_r >>> SHIFT;
    assign w_hi = w_s[W:DOUT_WIDTH-1];
    assign w_ov = ~((&w_hi) | ~(|w_hi));
    assign w_nar_o[i] = w_ov;
    assign w_nar_d[i*DOUT_WIDTH +: DOUT_WIDTH] =
      (w_ov && w_fin_sat) ? (w_s[W] ? C_MIN : C_MAX) : w_s[DOUT_WIDTH-1:0];
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_out_vld <= 1'b0;
      r_dout    <= '0;
      r_ovf     <= '0;
    end else if (ce) begin
      r_out_vld <= w_fin_vld;
      if (w_fin_vld) begin
        r_dout <= w_nar_d;
        r_ovf  <= w_nar_o;
      end
    end
  end

  assign out_valid = r_out_vld;
  assign dout      = r_dout;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_hls_mul_pipe_sat.sv
`default_nettype none
// tb_hls_mul_pipe_sat -- directed vector bench for hls_mul_pipe_sat (default, Q15 and 4-lane builds).
module tb_hls_mul_pipe_sat;

  logic        clk = 1'b0;
  logic        rst_n, ce, in_valid, sat_en, rnd_en;
  logic [15:0] din0_s, din1_s;
  logic [63:0] din0_l, din1_l;
  logic        ov_d, ov_q, ov_l;
  logic [15:0] dout_d, dout_q;
  logic [31:0] dout_l;
  logic [0:0]  ovf_d, ovf_q;
  logic [3:0]  ovf_l;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hls_mul_pipe_sat u_def (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .din0(din0_s), .din1(din1_s), .sat_en(sat_en), .rnd_en(rnd_en),
    .out_valid(ov_d), .dout(dout_d), .ovf(ovf_d)
  );

  hls_mul_pipe_sat #(.SHIFT(15)) u_q15 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .din0(din0_s), .din1(din1_s), .sat_en(sat_en), .rnd_en(rnd_en),
    .out_valid(ov_q), .dout(dout_q), .ovf(ovf_q)
  );

  hls_mul_pipe_sat #(.LANES(4), .DOUT_WIDTH(8)) u_l4 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .din0(din0_l), .din1(din1_l), .sat_en(sat_en), .rnd_en(rnd_en),
    .out_valid(ov_l), .dout(dout_l), .ovf(ovf_l)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic        r;
    logic [15:0] ed;   // default build: dout
    logic        eo;   // default build: ovf
    logic [15:0] eq;   // Q15 build: dout
    logic        eqo;  // Q15 build: ovf
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one operation then two bubbles; returns just after the result edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic r, input string tag);
    @(negedge clk);
    din0_s = a; din1_s = b; sat_en = s; rnd_en = r; in_valid = 1'b1; ce = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_lat1"}, ov_d, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_lat2"}, ov_d, 0);
    @(posedge clk); #1;
    chk({tag, "_lat3"}, ov_d, 1);
    chk({tag, "_lat3q"}, ov_q, 1);
  endtask

  logic [15:0] exp_s [8];
  logic        exp_so [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{16'd300,  16'd200,  1'b0, 1'b0, 16'hEA60, 1'b1, 16'h0001, 1'b0};
    vt[1]  = '{16'd300,  16'd200,  1'b1, 1'b0, 16'h7FFF, 1'b1, 16'h0001, 1'b0};
    vt[2]  = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1};
    vt[3]  = '{16'hFFF9, 16'd9,    1'b0, 1'b0, 16'hFFC1, 1'b0, 16'hFFFF, 1'b0};
    vt[4]  = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2000, 1'b0};
    vt[5]  = '{16'd3,    16'h4000, 1'b0, 1'b0, 16'hC000, 1'b1, 16'h0001, 1'b0};
    vt[6]  = '{16'd3,    16'h4000, 1'b0, 1'b1, 16'hC000, 1'b1, 16'h0002, 1'b0};
    vt[7]  = '{16'hFFFD, 16'h4000, 1'b0, 1'b0, 16'h4000, 1'b1, 16'hFFFE, 1'b0};
    vt[8]  = '{16'hFFFD, 16'h4000, 1'b0, 1'b1, 16'h4000, 1'b1, 16'hFFFF, 1'b0};
    vt[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h8000, 1'b1};
    vt[10] = '{16'd100,  16'hFE70, 1'b1, 1'b0, 16'h8000, 1'b1, 16'hFFFE, 1'b0};
    vt[11] = '{16'd181,  16'd181,  1'b0, 1'b0, 16'h7FF9, 1'b0, 16'h0000, 1'b0};

    exp_s  = '{16'h7530, 16'h7FFF, 16'hC350, 16'h7FFF, 16'h1170, 16'h7FFF, 16'h5F90, 16'h7FFF};
    exp_so = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0; ce = 1'b0; in_valid = 1'b0; sat_en = 1'b0; rnd_en = 1'b0;
    din0_s = '0; din1_s = '0; din0_l = '0; din1_l = '0;

    // Reset with ce=0 must still clear everything.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", ov_d, 0);
    chk("rst_dout", dout_d, 0);
    chk("rst_ovf", ovf_d, 0);
    chk("rst_dout_q", dout_q, 0);
    chk("rst_dout_l", dout_l, 0);
    chk("rst_ovf_l", ovf_l, 0);
    @(negedge clk);
    rst_n = 1'b1; ce = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].s, vt[i].r, $sformatf("v%0d", i));
      chk($sformatf("v%0d_dout", i), dout_d, vt[i].ed);
      chk($sformatf("v%0d_ovf", i), ovf_d, vt[i].eo);
      chk($sformatf("v%0d_q15_dout", i), dout_q, vt[i].eq);
      chk($sformatf("v%0d_q15_ovf", i), ovf_q, vt[i].eqo);
    end

    // ce freeze with one result at the output and one in flight.
    @(negedge clk);
    ce = 1'b1; in_valid = 1'b1; din0_s = 16'hFFF9; din1_s = 16'd9; sat_en = 1'b0; rnd_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    din0_s = 16'd300; din1_s = 16'd200; sat_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("frz_first_ov", ov_d, 1);
    chk("frz_first_dout", dout_d, 16'hFFC1);
    @(negedge clk);
    ce = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("frz%0d_ov", k), ov_d, 1);
      chk($sformatf("frz%0d_dout", k), dout_d, 16'hFFC1);
      chk($sformatf("frz%0d_ovf", k), ovf_d, 0);
    end
    @(negedge clk);
    ce = 1'b1;
    @(posedge clk); #1;
    chk("frz_second_ov", ov_d, 1);
    chk("frz_second_dout", dout_d, 16'h7FFF);
    chk("frz_second_ovf", ovf_d, 1);
    @(posedge clk); #1;
    chk("frz_after_ov", ov_d, 0);
    chk("frz_after_dout", dout_d, 16'h7FFF);

    // Back-to-back stream with sat_en toggling per operation.
    for (int e = 0; e < 11; e++) begin
      @(negedge clk);
      if (e < 8) begin
        in_valid = 1'b1; din0_s = 16'd1000; din1_s = 16'(30 + 10*e);
        sat_en = e[0]; rnd_en = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (e >= 2 && e <= 9) begin
        chk($sformatf("strm%0d_ov", e-2), ov_d, 1);
        chk($sformatf("strm%0d_dout", e-2), dout_d, exp_s[e-2]);
        chk($sformatf("strm%0d_ovf", e-2), ovf_d, exp_so[e-2]);
      end else begin
        chk($sformatf("strm_gap%0d_ov", e), ov_d, 0);
      end
    end

    // Reset (with ce=0) while two operations are in flight.
    @(negedge clk);
    in_valid = 1'b1; din0_s = 16'hFFF9; din1_s = 16'd9; sat_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    din0_s = 16'd300; din1_s = 16'd200;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; ce = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mrst_ov", ov_d, 0);
    chk("mrst_dout", dout_d, 0);
    chk("mrst_ovf", ovf_d, 0);
    @(negedge clk);
    rst_n = 1'b1; ce = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mrst_drain%0d_ov", k), ov_d, 0);
      chk($sformatf("mrst_drain%0d_dout", k), dout_d, 0);
    end
    run_op(16'd181, 16'd181, 1'b0, 1'b0, "post_rst");
    chk("post_rst_dout", dout_d, 16'h7FF9);
    chk("post_rst_ovf", ovf_d, 0);

    // Four-lane narrow build: saturate then wrap.
    din0_l = {16'hFF80, 16'd3, 16'hFFEC, 16'd10};
    din1_l = {16'hFFFF, 16'd3, 16'd7,    16'd12};
    run_op(16'd0, 16'd0, 1'b1, 1'b0, "l4s");
    chk("l4s_ov", ov_l, 1);
    chk("l4s_dout", dout_l, 32'h7F09_8078);
    chk("l4s_ovf", ovf_l, 4'b1010);
    run_op(16'd0, 16'd0, 1'b0, 1'b0, "l4w");
    chk("l4w_dout", dout_l, 32'h8009_7478);
    chk("l4w_ovf", ovf_l, 4'b1010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
